// File: rtl/dram_tx_streamer.sv
// rtl/dram_tx_streamer.sv - streams an image from data RAM out of an 8N1 UART line
module dram_tx_streamer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter int unsigned IMAGE_BYTES  = 16384
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_Tx,
  input  logic [7:0]  DRAM_data_Tx,
  output logic [15:0] DRAM_address_Tx,
  output logic        Tx,
  output logic        Tx_busy,
  output logic        Tx_done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [16:0] BYTE_LAST = 17'(IMAGE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [16:0] byte_q, byte_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] addr_q, addr_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trigger;
  logic        baud_end;

  // Only a fresh rising edge of start_Tx counts; a level held high never retriggers.
  assign trigger  = start_Tx & ~start_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state logic; the line level and status flags are computed from the
  // next state so that the registered outputs line up with the state register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_FETCH;
          addr_d  = START_ADDR;
          byte_d  = 17'd0;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = DRAM_data_Tx;
        baud_d  = 16'd0;
        state_d = S_START_BIT;
      end
      S_START_BIT: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA_BITS;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA_BITS: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP_BIT: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (byte_q == BYTE_LAST) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 17'd1;
            addr_d  = addr_q + 16'd1;
            state_d = S_FETCH;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DONE: begin
        addr_d  = START_ADDR;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START_BIT: tx_d = 1'b0;
      S_DATA_BITS: tx_d = shift_d[0];
      default:     tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 17'd0;
      shift_q <= 8'd0;
      addr_q  <= START_ADDR;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_Tx;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DRAM_address_Tx = addr_q;
  assign Tx              = tx_q;
  assign Tx_busy         = busy_q;
  assign Tx_done         = done_q;

endmodule

// File: tb/tb_dram_tx_streamer.sv
// tb/tb_dram_tx_streamer.sv - scoreboard bench for dram_tx_streamer
module tb_dram_tx_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn;
  logic [1:0]  start;
  logic [7:0]  rd0, rd1;
  logic [15:0] addr0, addr1;
  logic        tx0, tx1, busy0, busy1, done0, done1;

  logic [7:0]  mem [2][65536];
  logic [23:0] expq [2][$];
  bit          exp_done [2];
  int          done_cnt [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Instance 0: 4 clocks/bit, 3 bytes from 0x0010. Instance 1: minimum baud, address wrap.
  dram_tx_streamer #(.CLKS_PER_BIT(4), .START_ADDR(16'h0010), .IMAGE_BYTES(3)) u0 (
    .clock(clk), .reset_n(rstn[0]), .start_Tx(start[0]), .DRAM_data_Tx(rd0),
    .DRAM_address_Tx(addr0), .Tx(tx0), .Tx_busy(busy0), .Tx_done(done0));

  dram_tx_streamer #(.CLKS_PER_BIT(2), .START_ADDR(16'hFFFF), .IMAGE_BYTES(2)) u1 (
    .clock(clk), .reset_n(rstn[1]), .start_Tx(start[1]), .DRAM_data_Tx(rd1),
    .DRAM_address_Tx(addr1), .Tx(tx1), .Tx_busy(busy1), .Tx_done(done1));

  // Synchronous RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    rd0 <= mem[0][addr0];
    rd1 <= mem[1][addr1];
  end

  function automatic int cpb_of(input int g);
    return (g != 0) ? 2 : 4;
  endfunction
  function automatic logic [15:0] sa_of(input int g);
    return (g != 0) ? 16'hFFFF : 16'h0010;
  endfunction
  function automatic int nb_of(input int g);
    return (g != 0) ? 2 : 3;
  endfunction
  function automatic int pb_of(input int g);
    return 2 + 10 * cpb_of(g);
  endfunction
  function automatic logic get_tx(input int g);
    return (g != 0) ? tx1 : tx0;
  endfunction
  function automatic logic get_busy(input int g);
    return (g != 0) ? busy1 : busy0;
  endfunction
  function automatic logic get_done(input int g);
    return (g != 0) ? done1 : done0;
  endfunction
  function automatic logic [15:0] get_addr(input int g);
    return (g != 0) ? addr1 : addr0;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, g, act, exp);
    end
  endtask

  // Monitor: decodes UART frames and done pulses, checks against the scoreboard.
  task automatic monitor(input int g);
    int          cpb = cpb_of(g);
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    int          cnt = 0;
    bit          coll = 1'b0;
    int          ns = 0;
    logic        samp [40];
    logic [15:0] faddr;
    logic [9:0]  got;
    logic [9:0]  expf;
    logic [23:0] e;
    bit          wid_ok;
    forever begin
      @(negedge clk);
      if (prev_done)
        check("after_done_busy_done", g, 32'({get_busy(g), get_done(g)}), 32'd0);
      if (get_busy(g) && !prev_busy) cnt = 0;
      else if (get_busy(g)) cnt++;
      if (get_done(g)) begin
        check("done_expected", g, 32'(exp_done[g]), 32'd1);
        check("done_latency", g, 32'(cnt), 32'(nb_of(g) * pb_of(g)));
        exp_done[g] = 1'b0;
        done_cnt[g]++;
      end
      prev_busy = get_busy(g);
      prev_done = get_done(g);

      if (!coll && get_busy(g) && get_tx(g) == 1'b0) begin
        coll  = 1'b1;
        ns    = 0;
        faddr = get_addr(g);
      end
      if (coll) begin
        if (!get_busy(g)) begin
          coll = 1'b0;
        end else begin
          samp[ns] = get_tx(g);
          ns++;
          if (ns == 10 * cpb) begin
            coll   = 1'b0;
            wid_ok = 1'b1;
            for (int j = 0; j < 10; j++) begin
              got[j] = samp[j * cpb];
              for (int k = 0; k < cpb; k++)
                if (samp[j * cpb + k] !== got[j]) wid_ok = 1'b0;
            end
            check("bit_width", g, 32'(wid_ok), 32'd1);
            if (expq[g].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_frame[%0d]: got frame %0h at addr %0h, no frame expected", g, got, faddr);
            end else begin
              e    = expq[g].pop_front();
              expf = {1'b1, e[7:0], 1'b0};
              check("frame", g, 32'(got), 32'(expf));
              check("frame_addr", g, 32'(faddr), 32'(e[23:8]));
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // mode 0: plain pulse; mode 1: start held high plus extra edge mid-byte 2;
  // mode 2: reset during the data bits of byte 2.
  task automatic xfer(input int g, input int mode);
    int          cpb = cpb_of(g);
    int          pb  = pb_of(g);
    int          len = nb_of(g) * pb;
    int          d0  = done_cnt[g];
    logic [15:0] a;
    for (int k = 0; k < nb_of(g); k++) begin
      a = 16'(sa_of(g) + 16'(k));
      mem[g][a] = 8'($urandom);
      expq[g].push_back({a, mem[g][a]});
    end
    exp_done[g] = (mode != 2);
    @(negedge clk);
    start[g] = 1'b1;
    for (int i = 0; i < len + 100; i++) begin
      @(negedge clk);
      if (mode != 1 && i == 0) start[g] = 1'b0;
      if (mode == 1 && i == pb + 2 + 4 * cpb) start[g] = 1'b0;
      if (mode == 1 && i == pb + 3 + 4 * cpb) start[g] = 1'b1;
      if (mode == 2 && i == pb + 2 + 3 * cpb) rstn[g] = 1'b0;
      if (mode == 2 && i == pb + 3 + 3 * cpb) begin
        check("reset_tx", g, 32'(get_tx(g)), 32'd1);
        check("reset_busy", g, 32'(get_busy(g)), 32'd0);
        check("reset_done", g, 32'(get_done(g)), 32'd0);
        rstn[g] = 1'b1;
        expq[g].delete();
      end
    end
    start[g] = 1'b0;
    check("done_count", g, 32'(done_cnt[g] - d0), (mode == 2) ? 32'd0 : 32'd1);
    check("frames_left", g, 32'(expq[g].size()), 32'd0);
    check("idle_busy", g, 32'(get_busy(g)), 32'd0);
    check("idle_tx", g, 32'(get_tx(g)), 32'd1);
    check("idle_addr", g, 32'(get_addr(g)), 32'(sa_of(g)));
  endtask

  initial begin
    rstn  = 2'b00;
    start = 2'b00;
    exp_done[0] = 1'b0;
    exp_done[1] = 1'b0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    repeat (3) @(negedge clk);
    rstn = 2'b11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check("reset_idle_tx", g, 32'(get_tx(g)), 32'd1);
        check("reset_idle_busy", g, 32'(get_busy(g)), 32'd0);
        check("reset_idle_done", g, 32'(get_done(g)), 32'd0);
        check("reset_idle_addr", g, 32'(get_addr(g)), 32'(sa_of(g)));
      end
    end
    for (int g = 0; g < 2; g++) begin
      xfer(g, 0);
      xfer(g, 0);
      xfer(g, 1);
      xfer(g, 2);
      xfer(g, 0);
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
